btn_conditioner: RTL

Conditions one raw pushbutton ahead of the stopwatch control logic. Per button, in order: 2-FF synchronizer, counter-based debounce FSM, press/release one-cycle pulses, long-press detection, and (optional) auto-repeat. One instance per button: btnS feeds rst generation, btnR feeds pause toggle and adjust stepping. All logic runs in the system clk domain; no derived clocks.

---
 rtl/btn_pkg.sv | 23 ++
 rtl/btn_conditioner_if.sv | 29 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/btn_conditioner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the pushbutton conditioner.
package btn_pkg;

    // Debounce / hold FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StDbPress,
        StPressed,
        StLong,
        StDbRelease
    } btn_state_e;

    // Default cycle counts for a 100 MHz system clock.
    localparam int unsigned DebounceCyclesDefault = 1000000;   // 10 ms
    localparam int unsigned HoldCyclesDefault     = 100000000; // 1 s
    localparam int unsigned RepeatCyclesDefault   = 25000000;  // 4 Hz

    // Counter width for a count of n cycles; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Conditioned-button bundle: raw button in, debounced level and event pulses out.
interface btn_conditioner_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_hold;
    logic btn_repeat;

    // Consumer / stimulus side.
    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_hold,
        input  btn_repeat
    );

    // Conditioner side.
    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_hold,
        output btn_repeat
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: synchronizer, counter debounce, press/release pulses,
// long-press detection and optional auto-repeat.
// Optional feature macro: BTN_REPEAT_EN (defined -> btn_repeat pulses while
// long-pressed; undefined -> btn_repeat tied low and the repeat counter is absent).
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned HOLD_CYCLES     = HoldCyclesDefault,
    parameter int unsigned REPEAT_CYCLES   = RepeatCyclesDefault
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus_io
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HW = cnt_width(HOLD_CYCLES);
    localparam logic [DW-1:0] DcntMax = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HcntMax = HW'(HOLD_CYCLES - 1);

    // Reject zero cycle counts at elaboration.
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : gen_bad_params
        $error("btn_conditioner: cycle counts must be >= 1");
    end

    logic       s;
    btn_state_e state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic hold_q, hold_d;

`ifdef BTN_REPEAT_EN
    localparam int unsigned RW = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] RcntMax = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic repeat_q, repeat_d;
`endif

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus_io.btn_in),
        .q_o (s)
    );

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
            rcnt_q    <= '0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
`ifdef BTN_REPEAT_EN
            rcnt_q    <= rcnt_d;
            repeat_q  <= repeat_d;
`endif
        end
    end

    // Next-state logic; pulses default low so they last exactly one cycle.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        hold_d    = hold_q;
`ifdef BTN_REPEAT_EN
        rcnt_d    = rcnt_q;
        repeat_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (s) begin
                    state_d = StDbPress;
                    dcnt_d  = '0;
                end
            end
            StDbPress: begin
                if (!s) begin
                    state_d = StIdle;
                end else if (dcnt_q == DcntMax) begin
                    state_d = StPressed;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!s) begin
                    // hcnt is left untouched so a release bounce resumes timing.
                    state_d = StDbRelease;
                    dcnt_d  = '0;
                end else if (hcnt_q == HcntMax) begin
                    state_d  = StLong;
                    hold_d   = 1'b1;
`ifdef BTN_REPEAT_EN
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
`endif
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            StLong: begin
                if (!s) begin
                    state_d = StDbRelease;
                    dcnt_d  = '0;
                end
`ifdef BTN_REPEAT_EN
                else if (rcnt_q == RcntMax) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
`endif
            end
            StDbRelease: begin
                if (s) begin
                    // Bounce: go back to where we came from, counters resume.
                    state_d = hold_q ? StLong : StPressed;
                end else if (dcnt_q == DcntMax) begin
                    state_d   = StIdle;
                    level_d   = 1'b0;
                    hold_d    = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.btn_level   = level_q;
    assign bus_io.btn_press   = press_q;
    assign bus_io.btn_release = release_q;
    assign bus_io.btn_hold    = hold_q;
`ifdef BTN_REPEAT_EN
    assign bus_io.btn_repeat  = repeat_q;
`else
    assign bus_io.btn_repeat  = 1'b0;
`endif

endmodule
